reg_wb_arbiter: RTL and testbench

REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

---
 rtl/rv_pkg.sv | 6 +
 rtl/rr_arbiter.sv | 39 +++
 rtl/reg_wb_arbiter.sv | 72 +++++++
 tb/tb_reg_wb_arbiter.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// rv_pkg: shared core widths for the register-file writeback path.
package rv_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NREG       = 32;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant with a pointer that advances past the winner.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] valid,
    input  logic         flush,
    output logic [N-1:0] grant
);
    localparam int PW = N > 1 ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q, ptr_d, gidx;
    logic          found;

    always_comb begin
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && valid[(int'(ptr_q) + k) % N]) begin
                grant[(int'(ptr_q) + k) % N] = 1'b1;
                gidx  = PW'((int'(ptr_q) + k) % N);
                found = 1'b1;
            end
        end
        // Grants are suppressed while reset is held, not just on the next edge.
        if (!rst || flush) begin
            grant = '0;
            found = 1'b0;
        end
        ptr_d = flush ? '0 : !found ? ptr_q : (gidx == PW'(N - 1)) ? '0 : gidx + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ptr_q <= '0;
        else      ptr_q <= ptr_d;
    end
endmodule

// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: arbitrates writeback requesters onto one register-file write port
// and tracks pending destination registers in a busy scoreboard.
module reg_wb_arbiter import rv_pkg::*; #(
    parameter int NREQ = 3,
    parameter int XLEN = rv_pkg::XLEN
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NREQ-1:0]              req_valid,
    input  logic [NREQ*REG_ADDR_W-1:0]   req_addr,
    input  logic [NREQ*XLEN-1:0]         req_data,
    output logic [NREQ-1:0]              req_ready,
    input  logic                         alloc_valid,
    input  logic [REG_ADDR_W-1:0]        alloc_addr,
    input  logic                         flush,
    output logic                         writepass,
    output logic [REG_ADDR_W-1:0]        waddr,
    output logic [XLEN-1:0]              wdata,
    output logic [NREG-1:0]              busy
);
    logic                  wp_q, wp_d;
    logic [REG_ADDR_W-1:0] waddr_q, waddr_d, sel_addr;
    logic [XLEN-1:0]       wdata_q, wdata_d, sel_data;
    logic [NREG-1:0]       busy_q, busy_d;

    rr_arbiter #(.N(NREQ)) u_rr (
        .clk   (clk),
        .rst   (rst),
        .valid (req_valid),
        .flush (flush),
        .grant (req_ready)
    );

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                sel_addr = req_addr[i*REG_ADDR_W +: REG_ADDR_W];
                sel_data = req_data[i*XLEN +: XLEN];
            end
        end
        // x0 writes are consumed but never reach the register file.
        wp_d    = |req_ready && sel_addr != '0;
        waddr_d = |req_ready ? sel_addr : waddr_q;
        wdata_d = |req_ready ? sel_data : wdata_q;
        busy_d  = busy_q;
        if (wp_q) busy_d[waddr_q] = 1'b0;
        if (alloc_valid && alloc_addr != '0) busy_d[alloc_addr] = 1'b1;
        if (flush) busy_d = '0;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            busy_q  <= '0;
        end else begin
            wp_q    <= wp_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
        end
    end

    assign writepass = wp_q;
    assign waddr     = waddr_q;
    assign wdata     = wdata_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_reg_wb_arbiter.sv
// tb_reg_wb_arbiter: directed checks of grant order, writeback latency, scoreboard, flush and reset.
module tb_reg_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  req_valid = '0;
    logic [14:0] req_addr = '0;
    logic [95:0] req_data = '0;
    logic [2:0]  req_ready;
    logic        alloc_valid = 1'b0;
    logic [4:0]  alloc_addr = '0;
    logic        flush = 1'b0;
    logic        writepass;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] busy;
    int          n_chk = 0;
    int          n_err = 0;

    reg_wb_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .alloc_valid (alloc_valid),
        .alloc_addr  (alloc_addr),
        .flush       (flush),
        .writepass   (writepass),
        .waddr       (waddr),
        .wdata       (wdata),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alloc(input logic [4:0] a);
        alloc_valid = 1'b1;
        alloc_addr  = a;
        tick();
        alloc_valid = 1'b0;
    endtask

    initial begin
        req_valid = 3'b111;
        req_addr  = {5'd3, 5'd2, 5'd1};
        #12;
        check("rst_ready", req_ready, 3'b000);
        check("rst_wp", writepass, 0);
        check("rst_waddr", waddr, 0);
        check("rst_wdata", wdata, 0);
        check("rst_busy", busy, 0);
        req_valid = '0;
        rst = 1'b1;
        tick();

        alloc(5'd5);
        check("alloc_x5", busy, 32'h20);
        req_valid = 3'b001;
        req_addr  = {5'd0, 5'd0, 5'd5};
        req_data  = {32'h0, 32'h0, 32'hDEADBEEF};
        #1 check("single_ready", req_ready, 3'b001);
        tick();
        req_valid = '0;
        check("single_wp", writepass, 1);
        check("single_waddr", waddr, 5);
        check("single_wdata", wdata, 32'hDEADBEEF);
        check("single_busy_pend", busy, 32'h20);
        check("single_ptr", dut.u_rr.ptr_q, 1);
        tick();
        check("idle_wp", writepass, 0);
        check("idle_waddr_hold", waddr, 5);
        check("idle_wdata_hold", wdata, 32'hDEADBEEF);
        check("single_busy_clr", busy, 0);

        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_ptr0", dut.u_rr.ptr_q, 0);
        req_valid = 3'b111;
        req_addr  = {5'd3, 5'd2, 5'd1};
        req_data  = {32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001};
        #1 check("rr_g0", req_ready, 3'b001);
        tick();
        check("rr_wa1", waddr, 1);
        check("rr_wd1", wdata, 32'hAAAA0001);
        check("rr_g1", req_ready, 3'b010);
        tick();
        check("rr_wa2", waddr, 2);
        check("rr_wp2", writepass, 1);
        check("rr_g2", req_ready, 3'b100);
        tick();
        check("rr_wa3", waddr, 3);
        check("rr_wd3", wdata, 32'hCCCC0003);
        check("rr_g3", req_ready, 3'b001);
        tick();
        req_valid = '0;
        check("rr_wa4", waddr, 1);
        check("rr_ptr", dut.u_rr.ptr_q, 1);
        tick();

        req_valid = 3'b010;
        req_addr  = {5'd0, 5'd0, 5'd0};
        #1 check("x0_ready", req_ready, 3'b010);
        tick();
        req_valid = '0;
        check("x0_wp", writepass, 0);
        check("x0_ptr", dut.u_rr.ptr_q, 2);

        alloc(5'd7);
        check("race_pre", busy, 32'h80);
        req_valid = 3'b001;
        req_addr  = {5'd0, 5'd0, 5'd7};
        #1 check("wrap_ready", req_ready, 3'b001);
        tick();
        req_valid = '0;
        check("race_wp", writepass, 1);
        check("race_waddr", waddr, 7);
        alloc(5'd7);
        check("race_busy7", busy, 32'h80);
        alloc(5'd0);
        check("alloc_x0", busy, 32'h80);

        alloc(5'd4);
        alloc(5'd5);
        alloc(5'd6);
        check("flush_pre", busy, 32'hF0);
        req_valid = 3'b111;
        req_addr  = {5'd3, 5'd2, 5'd1};
        flush = 1'b1;
        alloc_valid = 1'b1;
        alloc_addr  = 5'd9;
        #1 check("flush_ready", req_ready, 3'b000);
        tick();
        flush = 1'b0;
        alloc_valid = 1'b0;
        req_valid = '0;
        check("flush_busy", busy, 0);
        check("flush_wp", writepass, 0);
        check("flush_ptr", dut.u_rr.ptr_q, 0);

        req_valid = 3'b001;
        req_addr  = {5'd0, 5'd0, 5'd3};
        req_data  = {32'h0, 32'h0, 32'h12345678};
        tick();
        check("ar_wp_pre", writepass, 1);
        #2 rst = 1'b0;
        #1;
        check("ar_wp", writepass, 0);
        check("ar_waddr", waddr, 0);
        check("ar_ready", req_ready, 3'b000);
        req_valid = '0;
        tick();
        rst = 1'b1;
        tick();
        check("ar_post1", writepass, 0);
        tick();
        check("ar_post2", writepass, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
